// File: rtl/decoder_pulse_pkg.sv
// Shared types and helpers for the multi-channel first-pulse decoder.
// Optional thermometer output is controlled by macro DECODER_PULSE_THERMO_OUT_EN.
// No logic here, only the state encoding and conversion helpers.
package decoder_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WINDOW = 2'd1,
    HOLD   = 2'd2
  } decoder_state_t;

  // A channel that never fires reports the window length itself as its time.
  function automatic int unsigned no_spike_time(input int unsigned max_v);
    return max_v;
  endfunction

  // Bit b of the LSB-aligned thermometer code holding (max_v - t) ones.
  function automatic logic thermo_bit(input int unsigned t, input int unsigned max_v,
                                      input int unsigned b);
    return (b + t) < max_v;
  endfunction

endpackage

// File: rtl/decoder_pulse_multi_if.sv
// Handshake/bus bundle between the decoder and its driver/consumer.
// Carries outgoing_thermo only when DECODER_PULSE_THERMO_OUT_EN is defined.
// slave = decoder side, master = stimulus/consumer side.
interface decoder_pulse_multi_if #(
  parameter int MAX_VALUE    = 8,
  parameter int NUM_CHANNELS = 4
);
  localparam int TIME_W = $clog2(MAX_VALUE + 1);

  logic                             start;
  logic [NUM_CHANNELS-1:0]          incoming_lines;
  logic                             busy;
  logic                             outgoing_valid;
  logic                             outgoing_ready;
  logic [NUM_CHANNELS*TIME_W-1:0]   outgoing_times;
  logic [NUM_CHANNELS-1:0]          outgoing_spiked;
`ifdef DECODER_PULSE_THERMO_OUT_EN
  logic [NUM_CHANNELS*MAX_VALUE-1:0] outgoing_thermo;
`endif

  modport slave (
    input  start, incoming_lines, outgoing_ready,
    output busy, outgoing_valid, outgoing_times, outgoing_spiked
`ifdef DECODER_PULSE_THERMO_OUT_EN
    , output outgoing_thermo
`endif
  );

  modport master (
    output start, incoming_lines, outgoing_ready,
    input  busy, outgoing_valid, outgoing_times, outgoing_spiked
`ifdef DECODER_PULSE_THERMO_OUT_EN
    , input outgoing_thermo
`endif
  );

endinterface

// File: rtl/decoder_pulse_channel.sv
// Per-channel first-pulse latch: records the counter value of the first high sample.
// Latency: time/spiked update on the edge that samples the pulse.
// clear has priority over enable; later pulses are ignored once spiked.
module decoder_pulse_channel
  import decoder_pulse_pkg::*;
#(
  parameter int MAX_VALUE = 8,
  parameter int TIME_W    = $clog2(MAX_VALUE + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic              line,
  input  logic [TIME_W-1:0] counter,
  output logic [TIME_W-1:0] chan_time,
  output logic              chan_spiked,
  output logic [TIME_W-1:0] chan_time_nxt
);

  localparam logic [TIME_W-1:0] NO_SPIKE = TIME_W'(no_spike_time(MAX_VALUE));

  logic [TIME_W-1:0] time_q, time_d;
  logic              spiked_q, spiked_d;

  // Next latch value: clear re-arms, otherwise capture only the first pulse.
  always_comb begin
    time_d   = time_q;
    spiked_d = spiked_q;
    if (clear) begin
      time_d   = NO_SPIKE;
      spiked_d = 1'b0;
    end else if (enable && line && !spiked_q) begin
      time_d   = counter;
      spiked_d = 1'b1;
    end
  end

  // Latch registers with synchronous reset to the no-spike encoding.
  always_ff @(posedge clock) begin
    if (reset) begin
      time_q   <= NO_SPIKE;
      spiked_q <= 1'b0;
    end else begin
      time_q   <= time_d;
      spiked_q <= spiked_d;
    end
  end

  assign chan_time     = time_q;
  assign chan_spiked   = spiked_q;
  assign chan_time_nxt = time_d;

endmodule

// File: rtl/decoder_pulse_multi.sv
// Multi-channel temporal decoder: start opens a MAX_VALUE-cycle window, first pulse time per line.
// Latency: result valid MAX_VALUE+1 cycles after the start cycle; optional thermo via DECODER_PULSE_THERMO_OUT_EN.
// Result is held frozen until outgoing_ready; ready+start in HOLD restarts with no idle gap.
module decoder_pulse_multi
  import decoder_pulse_pkg::*;
#(
  parameter int MAX_VALUE    = 8,
  parameter int NUM_CHANNELS = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  decoder_pulse_multi_if.slave bus
);

  localparam int                TIME_W = $clog2(MAX_VALUE + 1);
  localparam logic [TIME_W-1:0] LAST   = TIME_W'(MAX_VALUE - 1);

  decoder_state_t    state_q, state_d;
  logic [TIME_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              clear, enable, close;

  logic [NUM_CHANNELS*TIME_W-1:0] times_w;
  logic [NUM_CHANNELS*TIME_W-1:0] times_nxt_w;
  logic [NUM_CHANNELS-1:0]        spiked_w;

  // Window framing: next state, counter, and channel clear/enable strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clear   = 1'b0;
    enable  = 1'b0;
    close   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        clear = 1'b1;
        if (bus.start) state_d = WINDOW;
      end
      WINDOW: begin
        enable = 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          close   = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        cnt_d = '0;
        if (bus.outgoing_ready) begin
          if (bus.start) begin
            clear   = 1'b1;
            state_d = WINDOW;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == HOLD);
  end

  // FSM, counter and registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
    decoder_pulse_channel #(
      .MAX_VALUE (MAX_VALUE),
      .TIME_W    (TIME_W)
    ) u_chan (
      .clock         (clock),
      .reset         (reset),
      .clear         (clear),
      .enable        (enable),
      .line          (bus.incoming_lines[g]),
      .counter       (cnt_q),
      .chan_time     (times_w[g*TIME_W +: TIME_W]),
      .chan_spiked   (spiked_w[g]),
      .chan_time_nxt (times_nxt_w[g*TIME_W +: TIME_W])
    );
  end

  assign bus.busy            = busy_q;
  assign bus.outgoing_valid  = valid_q;
  assign bus.outgoing_times  = times_w;
  assign bus.outgoing_spiked = spiked_w;

`ifdef DECODER_PULSE_THERMO_OUT_EN
  logic [NUM_CHANNELS*MAX_VALUE-1:0] thermo_q, thermo_d;

  // Thermometer image of the final times, captured on the window-closing edge.
  always_comb begin
    thermo_d = thermo_q;
    if (close) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        for (int b = 0; b < MAX_VALUE; b++) begin
          thermo_d[ch*MAX_VALUE + b] =
            thermo_bit(int'(times_nxt_w[ch*TIME_W +: TIME_W]), MAX_VALUE, b);
        end
      end
    end
  end

  // Thermometer register, all ones out of reset.
  always_ff @(posedge clock) begin
    if (reset) thermo_q <= '1;
    else       thermo_q <= thermo_d;
  end

  assign bus.outgoing_thermo = thermo_q;
`endif

endmodule

// File: tb/tb_decoder_pulse_multi.sv
// Directed bench for decoder_pulse_multi at MAX_VALUE=8, NUM_CHANNELS=4.
// Vector table of windows plus hand sequences for hold, back-to-back and reset.
// Also checks outgoing_thermo when DECODER_PULSE_THERMO_OUT_EN is defined.
module tb_decoder_pulse_multi;

  localparam int MAXV = 8;
  localparam int NCH  = 4;

  typedef struct {
    logic [3:0]      start_lines;
    logic [3:0][7:0] pulse;       // pulse[ch][k]: line ch high on window cycle k
    logic [15:0]     exp_times;
    logic [3:0]      exp_spiked;
  } vec_t;

  logic clock;
  logic reset;
  int   pass_cnt;
  int   total_cnt;
  vec_t vecs[5];

  decoder_pulse_multi_if #(.MAX_VALUE(MAXV), .NUM_CHANNELS(NCH)) bus ();

  decoder_pulse_multi #(.MAX_VALUE(MAXV), .NUM_CHANNELS(NCH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] tp(input int t0, input int t1, input int t2, input int t3);
    return {4'(t3), 4'(t2), 4'(t1), 4'(t0)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive_window(input logic [3:0][7:0] pulse, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      for (int ch = 0; ch < NCH; ch++) bus.incoming_lines[ch] = pulse[ch][k];
      tick();
    end
    bus.incoming_lines = '0;
  endtask

  task automatic run_window(input logic [3:0] start_lines, input logic [3:0][7:0] pulse);
    bus.start          = 1'b1;
    bus.incoming_lines = start_lines;
    tick();
    bus.start = 1'b0;
    drive_window(pulse, MAXV);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;

    vecs[0] = '{4'h0, {8'h00, 8'h80, 8'h08, 8'h01}, tp(0, 3, 7, 8), 4'b0111};
    vecs[1] = '{4'h0, {8'h00, 8'h00, 8'h24, 8'h00}, tp(8, 2, 8, 8), 4'b0010};
    vecs[2] = '{4'hF, {8'h00, 8'h00, 8'h00, 8'h00}, tp(8, 8, 8, 8), 4'b0000};
    vecs[3] = '{4'h0, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, tp(0, 0, 0, 0), 4'b1111};
    vecs[4] = '{4'h5, {8'h80, 8'h00, 8'h00, 8'hC0}, tp(6, 8, 8, 7), 4'b1001};

    reset              = 1'b1;
    bus.start          = 1'b0;
    bus.incoming_lines = '0;
    bus.outgoing_ready = 1'b0;
    tick();
    tick();
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_valid", 64'(bus.outgoing_valid), 64'd0);
    chk("rst_times", 64'(bus.outgoing_times), 64'(tp(8, 8, 8, 8)));
    chk("rst_spiked", 64'(bus.outgoing_spiked), 64'd0);
`ifdef DECODER_PULSE_THERMO_OUT_EN
    chk("rst_thermo", 64'(bus.outgoing_thermo), 64'hFFFF_FFFF);
`endif
    reset = 1'b0;
    tick();

    // Table of windows, each followed by an immediate accept.
    for (int v = 0; v < 5; v++) begin
      run_window(vecs[v].start_lines, vecs[v].pulse);
      chk($sformatf("v%0d_valid", v), 64'(bus.outgoing_valid), 64'd1);
      chk($sformatf("v%0d_busy", v), 64'(bus.busy), 64'd1);
      chk($sformatf("v%0d_times", v), 64'(bus.outgoing_times), 64'(vecs[v].exp_times));
      chk($sformatf("v%0d_spiked", v), 64'(bus.outgoing_spiked), 64'(vecs[v].exp_spiked));
`ifdef DECODER_PULSE_THERMO_OUT_EN
      if (v == 0) chk("v0_thermo", 64'(bus.outgoing_thermo), 64'h0001_1FFF);
`endif
      bus.outgoing_ready = 1'b1;
      tick();
      bus.outgoing_ready = 1'b0;
      chk($sformatf("v%0d_accept_valid", v), 64'(bus.outgoing_valid), 64'd0);
      tick();
    end

    // Back-pressure: result frozen while lines toggle and ready is low.
    run_window(vecs[0].start_lines, vecs[0].pulse);
    for (int i = 0; i < 5; i++) begin
      bus.incoming_lines = 4'($urandom);
      tick();
      chk($sformatf("hold%0d_times", i), 64'(bus.outgoing_times), 64'(tp(0, 3, 7, 8)));
      chk($sformatf("hold%0d_spiked", i), 64'(bus.outgoing_spiked), 64'b0111);
      chk($sformatf("hold%0d_valid", i), 64'(bus.outgoing_valid), 64'd1);
    end
    bus.incoming_lines = '0;
    bus.outgoing_ready = 1'b1;
    tick();
    bus.outgoing_ready = 1'b0;
    chk("hold_rel_valid", 64'(bus.outgoing_valid), 64'd0);
    chk("hold_rel_busy", 64'(bus.busy), 64'd0);
    tick();
    chk("idle_times", 64'(bus.outgoing_times), 64'(tp(8, 8, 8, 8)));

    // Back-to-back: ready and start together in HOLD.
    run_window(vecs[0].start_lines, vecs[0].pulse);
    bus.outgoing_ready = 1'b1;
    bus.start          = 1'b1;
    bus.incoming_lines = 4'hF;
    chk("b2b_first_times", 64'(bus.outgoing_times), 64'(tp(0, 3, 7, 8)));
    tick();
    bus.outgoing_ready = 1'b0;
    bus.start          = 1'b0;
    chk("b2b_busy", 64'(bus.busy), 64'd1);
    chk("b2b_valid_low", 64'(bus.outgoing_valid), 64'd0);
    chk("b2b_cleared", 64'(bus.outgoing_times), 64'(tp(8, 8, 8, 8)));
    drive_window(vecs[1].pulse, MAXV - 1);
    chk("b2b_early_valid", 64'(bus.outgoing_valid), 64'd0);
    bus.incoming_lines = '0;
    tick();
    chk("b2b_valid", 64'(bus.outgoing_valid), 64'd1);
    chk("b2b_times", 64'(bus.outgoing_times), 64'(tp(8, 2, 8, 8)));
    chk("b2b_spiked", 64'(bus.outgoing_spiked), 64'b0010);
    bus.outgoing_ready = 1'b1;
    tick();
    bus.outgoing_ready = 1'b0;
    tick();

    // Reset during window cycle 4 discards the partial result.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    drive_window({8'h00, 8'h00, 8'h00, 8'h02}, 4);
    reset              = 1'b1;
    bus.incoming_lines = 4'hF;
    tick();
    reset              = 1'b0;
    bus.incoming_lines = '0;
    chk("rstmid_valid", 64'(bus.outgoing_valid), 64'd0);
    chk("rstmid_busy", 64'(bus.busy), 64'd0);
    chk("rstmid_times", 64'(bus.outgoing_times), 64'(tp(8, 8, 8, 8)));
    chk("rstmid_spiked", 64'(bus.outgoing_spiked), 64'd0);
    tick();
    run_window(vecs[0].start_lines, vecs[0].pulse);
    chk("post_rst_valid", 64'(bus.outgoing_valid), 64'd1);
    chk("post_rst_times", 64'(bus.outgoing_times), 64'(tp(0, 3, 7, 8)));
    bus.outgoing_ready = 1'b1;
    tick();
    bus.outgoing_ready = 1'b0;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
